// File: rtl/ssd_pkg.sv
// ============================================================================
// Module   : ssd_pkg
// Brief    : Shared 7-segment pattern constants and decoder state type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ssd_pkg;

  localparam logic [6:0] SSD_BLANK = 7'h00;

  // Segment order {g,f,e,d,c,b,a}; element i is the pattern for hex digit i.
  localparam logic [15:0][6:0] SSD_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    STABLE = 1'b1
  } ssd_state_e;

endpackage

`default_nettype wire

// File: rtl/ssd_pattern_lut.sv
// ============================================================================
// Module   : ssd_pattern_lut
// Brief    : Combinational reverse lookup of a segment pattern to its hex digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ssd_pattern_lut
  import ssd_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       hit_o,
  output logic [3:0] value_o,
  output logic       blank_o
);

  always_comb begin
    hit_o   = 1'b0;
    value_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SSD_HEX[i]) begin
        hit_o   = 1'b1;
        value_o = 4'(i);
      end
    end
    blank_o = (pattern_i == SSD_BLANK);
  end

endmodule

`default_nettype wire

// File: rtl/ssd_decoder.sv
// ============================================================================
// Module   : ssd_decoder
// Brief    : Glitch-filtered 7-segment pattern decoder with valid/ready output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ssd_decoder
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] ssd_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] binary_out,
  output logic       blank_out,
  output logic       illegal_out,
  output logic       overrun
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]    s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  ssd_state_e    state_q, state_d;
  logic          valid_q, valid_d;
  logic [3:0]    bin_q, bin_d;
  logic          blank_q, blank_d;
  logic          ill_q, ill_d;
  logic          ovr_q, ovr_d;

  logic          w_changed;
  logic          w_load;
  logic          w_hit;
  logic [3:0]    w_value;
  logic          w_blank;

  ssd_pattern_lut u_lut (
    .pattern_i (ssd_in),
    .hit_o     (w_hit),
    .value_o   (w_value),
    .blank_o   (w_blank)
  );

  always_comb begin
    w_changed = (ssd_in != s_q);
    cnt_d     = cnt_q;
    state_d   = state_q;
    valid_d   = valid_q;
    bin_d     = bin_q;
    blank_d   = blank_q;
    ill_d     = ill_q;
    ovr_d     = ovr_q;

    if (w_changed) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // A change seen in STABLE only loads immediately when one edge suffices.
    w_load = ((state_q == SETTLE) || w_changed) && (cnt_d == CNT_MAX);

    if (w_load) begin
      state_d = STABLE;
    end else if (w_changed) begin
      state_d = SETTLE;
    end

    if (w_load) begin
      valid_d = 1'b1;
      bin_d   = w_hit ? w_value : 4'h0;
      blank_d = w_blank;
      ill_d   = !w_hit && !w_blank;
      if (valid_q && !out_ready) begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= SSD_BLANK;
      cnt_q   <= '0;
      state_q <= SETTLE;
      valid_q <= 1'b0;
      bin_q   <= 4'h0;
      blank_q <= 1'b0;
      ill_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      s_q     <= ssd_in;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      valid_q <= valid_d;
      bin_q   <= bin_d;
      blank_q <= blank_d;
      ill_q   <= ill_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid   = valid_q;
  assign binary_out  = bin_q;
  assign blank_out   = blank_q;
  assign illegal_out = ill_q;
  assign overrun     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_ssd_decoder.sv
// ============================================================================
// Module   : tb_ssd_decoder
// Brief    : Directed vector bench for ssd_decoder (STABLE_CYCLES = 3 and 1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ssd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] ssd_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] binary_out;
  logic       blank_out, illegal_out, overrun;

  logic       rst1;
  logic [6:0] ssd_in1;
  logic       out_ready1;
  logic       out_valid1;
  logic [3:0] binary_out1;
  logic       blank_out1, illegal_out1, overrun1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ssd_decoder #(.STABLE_CYCLES(3)) u_dut (
    .clk(clk), .rst(rst), .ssd_in(ssd_in), .out_valid(out_valid),
    .out_ready(out_ready), .binary_out(binary_out), .blank_out(blank_out),
    .illegal_out(illegal_out), .overrun(overrun)
  );

  ssd_decoder #(.STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1), .ssd_in(ssd_in1), .out_valid(out_valid1),
    .out_ready(out_ready1), .binary_out(binary_out1), .blank_out(blank_out1),
    .illegal_out(illegal_out1), .overrun(overrun1)
  );

  logic [6:0] hex_tbl [16];

  typedef struct {
    logic       rst;
    logic [6:0] pat;
    logic       rdy;
    int         edges;
    logic       v;
    logic [3:0] b;
    logic       bl;
    logic       il;
    logic       ov;
    logic       cd;
  } vec_t;

  vec_t vec [25];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    //         rst pat    rdy edges v  b     bl il ov cd
    vec[0]  = '{1, 7'h00, 1, 2, 0, 4'h0, 0, 0, 0, 1};
    vec[1]  = '{0, 7'h00, 1, 2, 0, 4'h0, 0, 0, 0, 1};
    vec[2]  = '{0, 7'h00, 1, 1, 1, 4'h0, 1, 0, 0, 1};
    vec[3]  = '{0, 7'h01, 1, 1, 0, 4'h0, 0, 0, 0, 0};
    vec[4]  = '{0, 7'h01, 1, 2, 1, 4'h0, 0, 1, 0, 1};
    vec[5]  = '{0, 7'h7F, 1, 3, 1, 4'h8, 0, 0, 0, 1};
    vec[6]  = '{0, 7'h7F, 1, 1, 0, 4'h8, 0, 0, 0, 0};
    vec[7]  = '{0, 7'h39, 0, 3, 1, 4'hC, 0, 0, 0, 1};
    vec[8]  = '{0, 7'h07, 0, 2, 1, 4'hC, 0, 0, 0, 1};
    vec[9]  = '{0, 7'h07, 1, 1, 1, 4'h7, 0, 0, 0, 1};
    vec[10] = '{0, 7'h07, 1, 1, 0, 4'h7, 0, 0, 0, 0};
    vec[11] = '{0, 7'h06, 0, 3, 1, 4'h1, 0, 0, 0, 1};
    vec[12] = '{0, 7'h66, 0, 2, 1, 4'h1, 0, 0, 0, 1};
    vec[13] = '{0, 7'h66, 0, 1, 1, 4'h4, 0, 0, 1, 1};
    vec[14] = '{0, 7'h66, 1, 1, 0, 4'h4, 0, 0, 1, 0};
    vec[15] = '{0, 7'h5B, 1, 3, 1, 4'h2, 0, 0, 1, 1};
    vec[16] = '{0, 7'h5B, 1, 1, 0, 4'h2, 0, 0, 1, 0};
    vec[17] = '{0, 7'h5B, 1, 3, 0, 4'h2, 0, 0, 1, 0};
    vec[18] = '{0, 7'h4F, 1, 1, 0, 4'h2, 0, 0, 1, 0};
    vec[19] = '{0, 7'h5B, 1, 2, 0, 4'h2, 0, 0, 1, 0};
    vec[20] = '{0, 7'h5B, 1, 1, 1, 4'h2, 0, 0, 1, 1};
    vec[21] = '{0, 7'h7F, 0, 2, 1, 4'h2, 0, 0, 1, 1};
    vec[22] = '{1, 7'h7F, 0, 1, 0, 4'h0, 0, 0, 0, 1};
    vec[23] = '{0, 7'h7F, 1, 2, 0, 4'h0, 0, 0, 0, 1};
    vec[24] = '{0, 7'h7F, 1, 1, 1, 4'h8, 0, 0, 0, 1};

    rst = 1'b1; ssd_in = 7'h00; out_ready = 1'b1;
    rst1 = 1'b1; ssd_in1 = 7'h00; out_ready1 = 1'b1;
    step(1);

    for (int i = 0; i < 25; i++) begin
      rst = vec[i].rst; ssd_in = vec[i].pat; out_ready = vec[i].rdy;
      step(vec[i].edges);
      check($sformatf("vec%0d valid", i), int'(out_valid), int'(vec[i].v));
      check($sformatf("vec%0d overrun", i), int'(overrun), int'(vec[i].ov));
      if (vec[i].cd) begin
        check($sformatf("vec%0d binary", i), int'(binary_out), int'(vec[i].b));
        check($sformatf("vec%0d blank", i), int'(blank_out), int'(vec[i].bl));
        check($sformatf("vec%0d illegal", i), int'(illegal_out), int'(vec[i].il));
      end
    end

    // Loop-back sweep: each digit held 10 cycles, reported on its 3rd edge.
    out_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      ssd_in = hex_tbl[v];
      step(2);
      check($sformatf("sweep%0d early", v), int'(out_valid), 0);
      step(1);
      check($sformatf("sweep%0d valid", v), int'(out_valid), 1);
      check($sformatf("sweep%0d binary", v), int'(binary_out), v);
      check($sformatf("sweep%0d flags", v), int'({blank_out, illegal_out}), 0);
      step(7);
      check($sformatf("sweep%0d once", v), int'(out_valid), 0);
    end

    // Single-edge filter.
    rst1 = 1'b0; ssd_in1 = 7'h06;
    step(1);
    check("s1 first valid", int'(out_valid1), 1);
    check("s1 first binary", int'(binary_out1), 1);
    step(1);
    check("s1 no repeat", int'(out_valid1), 0);
    ssd_in1 = 7'h4F;
    step(1);
    check("s1 second valid", int'(out_valid1), 1);
    check("s1 second binary", int'(binary_out1), 3);
    ssd_in1 = 7'h5B; out_ready1 = 1'b0;
    step(1);
    check("s1 overwrite binary", int'(binary_out1), 2);
    check("s1 overrun", int'(overrun1), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
